// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 arbiter: cache word/line types, the grant FSM encoding
// and the Wishbone command bundle carried through the port mux.
package l2_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_8words;
  typedef logic [15:0]  lc3b_sel;
  typedef logic [11:0]  lc3b_l2_adr;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       cyc;
    logic       stb;
    logic       we;
    lc3b_sel    sel;
    lc3b_l2_adr adr;
    lc3b_8words dat;
  } wb_cmd_t;

endpackage

// File: rtl/l2_arbiter_wb_port_mux.sv
// Combinational 2:1 mux of one Wishbone master command bundle; with neither
// side selected every field is driven to zero.
module wb_port_mux
  import l2_arbiter_pkg::*;
(
  input  logic         sel_a,
  input  logic         sel_b,
  input  logic         a_cyc,
  input  logic         a_stb,
  input  logic         a_we,
  input  logic [15:0]  a_sel,
  input  logic [11:0]  a_adr,
  input  logic [127:0] a_dat_m,
  input  logic         b_cyc,
  input  logic         b_stb,
  input  logic         b_we,
  input  logic [15:0]  b_sel,
  input  logic [11:0]  b_adr,
  input  logic [127:0] b_dat_m,
  output logic         y_cyc,
  output logic         y_stb,
  output logic         y_we,
  output logic [15:0]  y_sel,
  output logic [11:0]  y_adr,
  output logic [127:0] y_dat_m
);

  wb_cmd_t cmd_a, cmd_b, cmd_y;

  assign cmd_a = '{cyc: a_cyc, stb: a_stb, we: a_we, sel: a_sel, adr: a_adr, dat: a_dat_m};
  assign cmd_b = '{cyc: b_cyc, stb: b_stb, we: b_we, sel: b_sel, adr: b_adr, dat: b_dat_m};

  always_comb begin
    cmd_y = '0;
    if (sel_a) begin
      cmd_y = cmd_a;
    end else if (sel_b) begin
      cmd_y = cmd_b;
    end
  end

  assign y_cyc   = cmd_y.cyc;
  assign y_stb   = cmd_y.stb;
  assign y_we    = cmd_y.we;
  assign y_sel   = cmd_y.sel;
  assign y_adr   = cmd_y.adr;
  assign y_dat_m = cmd_y.dat;

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin Wishbone arbiter sharing the L2 slave port between the L1 I- and
// D-caches, one whole transaction per grant, with per-requester grant counters.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             wb_icache_cyc,
  input  logic             wb_icache_stb,
  input  logic             wb_icache_we,
  input  logic [15:0]      wb_icache_sel,
  input  logic [11:0]      wb_icache_adr,
  input  logic [127:0]     wb_icache_dat_m,
  output logic [127:0]     wb_icache_dat_s,
  output logic             wb_icache_ack,
  output logic             wb_icache_rty,

  input  logic             wb_dcache_cyc,
  input  logic             wb_dcache_stb,
  input  logic             wb_dcache_we,
  input  logic [15:0]      wb_dcache_sel,
  input  logic [11:0]      wb_dcache_adr,
  input  logic [127:0]     wb_dcache_dat_m,
  output logic [127:0]     wb_dcache_dat_s,
  output logic             wb_dcache_ack,
  output logic             wb_dcache_rty,

  output logic             wb_l2_cyc,
  output logic             wb_l2_stb,
  output logic             wb_l2_we,
  output logic [15:0]      wb_l2_sel,
  output logic [11:0]      wb_l2_adr,
  output logic [127:0]     wb_l2_dat_m,
  input  logic [127:0]     wb_l2_dat_s,
  input  logic             wb_l2_ack,
  input  logic             wb_l2_rty,

  output logic [CNT_W-1:0] i_grant_count,
  output logic [CNT_W-1:0] d_grant_count
);

  arb_state_t       state_q, state_d;
  logic             last_d_q;
  logic [CNT_W-1:0] i_cnt_q, d_cnt_q;
  logic             req_i, req_d;
  logic             grant_i, grant_d;
  logic             inc_i, inc_d;

  assign req_i   = wb_icache_cyc & wb_icache_stb;
  assign req_d   = wb_dcache_cyc & wb_dcache_stb;
  assign grant_i = (state_q == GRANT_I);
  assign grant_d = (state_q == GRANT_D);

  // An ACK ends the grant even if the master drops CYC in the same cycle.
  assign inc_i = grant_i & wb_l2_ack;
  assign inc_d = grant_d & wb_l2_ack;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_i && (!req_d || last_d_q)) begin
          state_d = GRANT_I;
        end else if (req_d) begin
          state_d = GRANT_D;
        end
      end
      GRANT_I: begin
        if (wb_l2_ack || !wb_icache_cyc) begin
          state_d = IDLE;
        end
      end
      GRANT_D: begin
        if (wb_l2_ack || !wb_dcache_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      i_cnt_q  <= '0;
      d_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d != IDLE) begin
        last_d_q <= (state_d == GRANT_D);
      end
      i_cnt_q <= i_cnt_q + CNT_W'(inc_i);
      d_cnt_q <= d_cnt_q + CNT_W'(inc_d);
    end
  end

  wb_port_mux u_mux (
    .sel_a   (grant_i),
    .sel_b   (grant_d),
    .a_cyc   (wb_icache_cyc),
    .a_stb   (wb_icache_stb),
    .a_we    (wb_icache_we),
    .a_sel   (wb_icache_sel),
    .a_adr   (wb_icache_adr),
    .a_dat_m (wb_icache_dat_m),
    .b_cyc   (wb_dcache_cyc),
    .b_stb   (wb_dcache_stb),
    .b_we    (wb_dcache_we),
    .b_sel   (wb_dcache_sel),
    .b_adr   (wb_dcache_adr),
    .b_dat_m (wb_dcache_dat_m),
    .y_cyc   (wb_l2_cyc),
    .y_stb   (wb_l2_stb),
    .y_we    (wb_l2_we),
    .y_sel   (wb_l2_sel),
    .y_adr   (wb_l2_adr),
    .y_dat_m (wb_l2_dat_m)
  );

  // Read data is broadcast; only the granted master can see ACK, so the other
  // one observes a retry for as long as it keeps requesting.
  assign wb_icache_dat_s = wb_l2_dat_s;
  assign wb_dcache_dat_s = wb_l2_dat_s;
  assign wb_icache_ack   = grant_i & wb_l2_ack;
  assign wb_dcache_ack   = grant_d & wb_l2_ack;
  assign wb_icache_rty   = grant_i ? wb_l2_rty
                                   : (wb_icache_cyc & wb_icache_stb & ~wb_icache_ack);
  assign wb_dcache_rty   = grant_d ? wb_l2_rty
                                   : (wb_dcache_cyc & wb_dcache_stb & ~wb_dcache_ack);

  assign i_grant_count = i_cnt_q;
  assign d_grant_count = d_cnt_q;

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-requester Wishbone arbiter that lets the L1 instruction cache and the L1 data cache share the single slave port of the unified L2 cache. It sits between the two L1 master ports and the L2 slave port. It grants one whole transaction at a time using round-robin priority, and it muxes the granted master's command and write data onto the L2 port. It also keeps per-requester grant counters for the performance-counter readout.

## Interface
Parameters:
- CNT_W, 16, width of each grant counter (matches lc3b_word)

Ports (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active low
- wb_icache  wishbone.slave  bundle  I-cache request port (CYC, STB, WE, SEL[15:0], ADR[11:0], DAT_M[127:0] in; DAT_S[127:0], ACK, RTY out)
- wb_dcache  wishbone.slave  bundle  D-cache request port, same fields
- wb_l2  wishbone.master  bundle  L2 cache port, same fields with directions reversed
- i_grant_count  out  CNT_W  completed I-cache transactions, wraps modulo 2^CNT_W
- d_grant_count  out  CNT_W  completed D-cache transactions, wraps modulo 2^CNT_W

## Operation
- Request: req_i = wb_icache.CYC & wb_icache.STB; req_d = wb_dcache.CYC & wb_dcache.STB.
- States: IDLE, GRANT_I, GRANT_D. Priority pointer last_d is 1 when the D-cache was granted most recently.
- IDLE:
  - Only req_i asserted: go to GRANT_I.
  - Only req_d asserted: go to GRANT_D.
  - Both asserted: grant the requester that was not granted last. last_d=1 gives GRANT_I; last_d=0 gives GRANT_D.
  - Neither asserted: stay in IDLE.
- Entering a GRANT state: last_d updates to match the new grant.
- GRANT_x:
  - Drive CYC, STB, WE, SEL, ADR and DAT_M from master x onto wb_l2.
  - Route wb_l2.DAT_S to both slave ports. Route wb_l2.ACK only to master x.
  - Pass wb_l2.RTY through to master x.
- Leaving GRANT_x:
  - ACK from L2 in GRANT_x: go to IDLE next cycle and increment x's grant counter.
  - Master x drops CYC before ACK (abort): go to IDLE, no counter increment. wb_l2.CYC falls in the same cycle because the mux is combinational.
- Non-granted master:
  - ACK is forced to 0.
  - RTY = CYC & STB & !ACK, so the L1 controller sees a retry and holds its request.
- IDLE outputs:
  - wb_l2 CYC, STB and WE are 0. SEL, ADR and DAT_M are 0.
  - Both slave ACK outputs are 0. RTY follows the non-granted rule for both.
- Counter arithmetic is unsigned with natural wrap: 0xFFFF+1 gives 0x0000.
- A simultaneous ACK and abort in the same cycle counts as completed.

## Timing
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE, last_d to 1 (I-cache wins the first tie), both counters to 0.
  - All wb_l2 command outputs are 0 from the next cycle.
- Reset during a GRANT state abandons the transaction. The L2 sees CYC drop and must tolerate it.
- Arbitration latency: a request first seen in IDLE in cycle N appears on wb_l2 in cycle N+1.
- Return path: L2 ACK in cycle M reaches the granted master in cycle M, with no added delay.
- Hand-off: the state is IDLE in cycle M+1. The next grant is visible in cycle M+2, giving one bubble between back-to-back transactions.
- Combinational paths: all slave-to-master data and control are pure muxes selected by the registered state. There is no combinational path from a request to the grant.

## Structure
- arb_state_t enum (IDLE, GRANT_I, GRANT_D) goes in lc3b_types.
- Reuse lc3b_8words and lc3b_word from the same package.
- One sub-module, wb_port_mux: a combinational 2:1 mux of one Wishbone master bundle, selected by the grant. It isolates the wide datapath from the FSM.
- The FSM, priority pointer and counters live in l2_arbiter.

## Test plan
- I-cache only:
  - Stimulus: read of ADR 0x123 in cycle 1; L2 ACKs in cycle 5 with DAT_S = 128'hA5…A5.
  - Required: wb_l2.ADR = 0x123 in cycles 2–5; I-cache sees ACK and data in cycle 5; i_grant_count = 1; d_grant_count = 0.
- Simultaneous requests after reset:
  - Stimulus: both caches request in the same cycle.
  - Required: I-cache granted first; D-cache sees RTY = 1 until the I-cache ACK. D-cache granted two cycles after that ACK.
- Fairness:
  - Stimulus: both caches request continuously for 10 transactions.
  - Required: grants alternate I, D, I, D…; both counters end at 5.
- D-cache write pass-through:
  - Stimulus: WE = 1, SEL = 16'h00FF, DAT_M = 128'h0123…; I-cache idle.
  - Required: the same WE, SEL and DAT_M values appear on wb_l2 during the grant; the I-cache never sees ACK.
- Abort and reset:
  - Stimulus: the D-cache drops CYC mid-grant before ACK.
  - Required: wb_l2.CYC = 0 in the same cycle; d_grant_count is unchanged.
  - Stimulus: assert rst_n = 0 mid-grant.
  - Required: state returns to IDLE and both counters read 0.
- Counter wrap:
  - Stimulus: preload i_grant_count to 0xFFFF by forcing, then complete one I-cache transaction.
  - Required: i_grant_count reads 0x0000.
